// File: rtl/mvm_pkg.sv
// Shared types for the tiled matrix-vector scheduler: FSM states, pipeline tag
// layout and the default core latency helper.
package mvm_pkg;

  localparam int TAG_ROW_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic                 first_col;
    logic                 last_col;
    logic [TAG_ROW_W-1:0] row;
  } tag_t;

  // One multiply stage, one stage per adder-tree level, one output stage.
  function automatic int core_lat(input int cols);
    return 2 + $clog2(cols);
  endfunction

endpackage

// File: rtl/mvm_tag_pipe.sv
// Enable-gated tag shift register that shadows the core pipeline, so each core
// output can be matched to the tile (or bubble) that produced it.
module mvm_tag_pipe
  import mvm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  tag_t din,
  output tag_t dout,
  output logic any_valid
);

  tag_t tag [1:DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 1; k <= DEPTH; k++) tag[k] <= '0;
    end else if (en) begin
      tag[1] <= din;
      for (int k = 2; k <= DEPTH; k++) tag[k] <= tag[k-1];
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int k = 1; k <= DEPTH; k++) any_valid = any_valid | tag[k].valid;
  end

  assign dout = tag[DEPTH];

endmodule

// File: rtl/mvm_tile_scheduler.sv
// Runs a large matrix-vector product on one core by issuing tiles row-major,
// accumulating partial sums across column tiles and emitting one result per row tile.
//
// state | meaning
// IDLE  | waiting for start; cfg latched on start
// RUN   | requesting operand tiles until the last tile issues
// DRAIN | waiting for in-flight tiles and the output buffer to empty
// DONE  | one-cycle done pulse
module mvm_tile_scheduler
  import mvm_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int WIDTH      = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int CORE_LAT   = core_lat(COLS),
  parameter int TILE_IDX_W = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [TILE_IDX_W-1:0]     cfg_row_tiles,
  input  logic [TILE_IDX_W-1:0]     cfg_col_tiles,
  output logic                      busy,
  output logic                      done,
  output logic                      op_req,
  output logic [TILE_IDX_W-1:0]     op_row,
  output logic [TILE_IDX_W-1:0]     op_col,
  input  logic                      op_valid,
  output logic                      core_cen,
  input  logic [ROWS*WIDTH-1:0]     core_y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TILE_IDX_W-1:0]     out_row,
  output logic [ROWS*ACC_WIDTH-1:0] out_data
);

  state_t                state;
  logic [TILE_IDX_W-1:0] row_last;
  logic [TILE_IDX_W-1:0] col_last;
  logic                  stall;
  logic                  issue;
  logic                  last_issue;
  logic                  any_valid;
  logic                  consume;
  tag_t                  tag_in;
  tag_t                  tag_out;
  logic [ACC_WIDTH-1:0]  acc   [ROWS];
  logic [ACC_WIDTH-1:0]  y_ext [ROWS];

  // A full, unaccepted output buffer freezes the whole pipe, so no consume can overwrite it.
  assign stall      = out_valid && !out_ready;
  assign issue      = op_req && op_valid && !stall;
  assign core_cen   = !stall && (issue || any_valid);
  assign last_issue = issue && (op_row == row_last) && (op_col == col_last);
  assign consume    = core_cen && tag_out.valid;

  always_comb begin
    tag_in = '0;
    if (issue) begin
      tag_in.valid     = 1'b1;
      tag_in.first_col = (op_col == '0);
      tag_in.last_col  = (op_col == col_last);
      tag_in.row       = TAG_ROW_W'(op_row);
    end
  end

  always_comb begin
    for (int i = 0; i < ROWS; i++) y_ext[i] = ACC_WIDTH'($signed(core_y[i*WIDTH +: WIDTH]));
  end

  mvm_tag_pipe #(
    .DEPTH(CORE_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rstn     (rstn),
    .en       (core_cen),
    .din      (tag_in),
    .dout     (tag_out),
    .any_valid(any_valid)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      op_req   <= 1'b0;
      op_row   <= '0;
      op_col   <= '0;
      row_last <= '0;
      col_last <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            row_last <= cfg_row_tiles;
            col_last <= cfg_col_tiles;
            op_row   <= '0;
            op_col   <= '0;
            op_req   <= 1'b1;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (last_issue) begin
            op_req <= 1'b0;
            op_row <= '0;
            op_col <= '0;
            state  <= DRAIN;
          end else if (issue) begin
            if (op_col == col_last) begin
              op_col <= '0;
              op_row <= op_row + 1'b1;
            end else begin
              op_col <= op_col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!any_valid && (!out_valid || out_ready)) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy   <= 1'b0;
          op_req <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ROWS; i++) acc[i] <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_data  <= '0;
    end else begin
      if (consume) begin
        for (int i = 0; i < ROWS; i++) begin
          acc[i] <= tag_out.first_col ? y_ext[i] : acc[i] + y_ext[i];
          if (tag_out.last_col)
            out_data[i*ACC_WIDTH +: ACC_WIDTH] <= (tag_out.first_col ? '0 : acc[i]) + y_ext[i];
        end
      end
      if (consume && tag_out.last_col) begin
        out_valid <= 1'b1;
        out_row   <= TILE_IDX_W'(tag_out.row);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mvm_tile_scheduler.md
# mvm_tile_scheduler

Sequencer that runs a large matrix-vector product on one `matrix_vector_mul_core` instance by splitting the matrix into ROWS×COLS tiles. It requests operand tiles from the fetch unit in row-major tile order and drives the core's `cen`. It tracks each tile through the core pipeline with a tag shift register, accumulates partial sums across column tiles, and emits one wide result per row tile over a valid/ready port.

## Interface
- ROWS, 4, core rows per tile
- COLS, 4, core columns per tile
- WIDTH, 8, core element/result width (signed)
- ACC_WIDTH, 24, accumulator width per row
- CORE_LAT, 4, core pipeline depth in `cen` edges (1 multiply + clog2(COLS) tree levels + 1 output)
- TILE_IDX_W, 8, width of tile-count/index fields
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  launch job; sampled only in IDLE
- cfg_row_tiles  in  TILE_IDX_W  row tiles minus 1, latched on start
- cfg_col_tiles  in  TILE_IDX_W  column tiles minus 1, latched on start
- busy  out  1  high in every state other than IDLE
- done  out  1  one-cycle pulse at job end
- op_req  out  1  requesting operand tile (op_row, op_col)
- op_row, op_col  out  TILE_IDX_W each  requested tile coordinates
- op_valid  in  1  fetch unit presents x1/x2 for the requested tile directly at the core inputs
- core_cen  out  1  core clock enable
- core_y  in  ROWS*WIDTH  core output
- out_valid  out  1  row-tile result available
- out_ready  in  1  consumer accepts
- out_row  out  TILE_IDX_W  row-tile index of result
- out_data  out  ROWS*ACC_WIDTH  accumulated result, row i at [i*ACC_WIDTH +: ACC_WIDTH]

## Operation
- FSM states:
  - IDLE: on start, latch cfg, clear counters, go to RUN.
  - RUN: op_req=1. After the issue of tile (cfg_row_tiles, cfg_col_tiles), go to DRAIN.
  - DRAIN: op_req=0. When no tag is valid and the output buffer is empty (or handshaking this cycle), go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Tile order: col index increments first; it wraps to 0 with row+1 after cfg_col_tiles.
- stall = out_valid && !out_ready.
- issue = op_req && op_valid && !stall.
- core_cen = !stall && (issue || any tag valid). Bubbles (cen high, no issue) enter the pipe as invalid tags.
- Tag {valid, first_col, last_col, row} enters tag[1] on each cen edge; tag[k] <= tag[k-1]. Tags do not move when cen is low.
- Consume rule: on an edge with core_cen=1 and tag[CORE_LAT].valid, core_y belongs to that tag.
  - Each row slice is sign-extended WIDTH→ACC_WIDTH.
  - first_col: acc <= sext(core_y). Otherwise acc <= acc + sext(core_y).
  - last_col: out_data <= (first_col ? 0 : acc) + sext(core_y); out_row <= tag.row; out_valid <= 1.
- Arithmetic is modulo 2^ACC_WIDTH: wrap, no saturation.
- The output buffer is single-entry. out_valid clears on handshake unless a new last_col consume occurs on the same edge, in which case it stays high with the new data. Because of the stall rule, a consume cannot occur while the buffer is full and unready.
- op_row/op_col hold stable while op_req && !issue.
- start outside IDLE is ignored. cfg changes after start are ignored.
- Async reset mid-job: FSM to IDLE, all tags invalid, acc=0, outputs at reset values. Partial results are discarded.

## Timing
- Reset values: busy=0, done=0, op_req=0, op_row=op_col=0, core_cen=0, out_valid=0, out_row=0, out_data=0.
- Start in cycle 0 → RUN and op_req in cycle 1.
- Issue in cycle t with no stalls → out_valid in cycle t+CORE_LAT+1 for a single column tile.
- Full throughput: one tile per cycle while op_valid=1 and out_ready=1.
- The last result handshake in cycle h → done in cycle h+1 → IDLE in h+2. start can be accepted in cycle h+2.
- With op_valid low, the pipe keeps draining earlier tiles: no deadlock, no loss.

## Structure
- Package `mvm_pkg`:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - tag struct {valid, first_col, last_col, row}
  - function core_lat(cols) = 2 + $clog2(cols), used as the CORE_LAT default
- Sub-module `mvm_tag_pipe`: CORE_LAT-deep enable-gated tag shift register with an any_valid output.
- Accumulator and output buffer stay in the top module.

## Test plan
- cfg 0/0, op_valid=1, out_ready=1, core_y rows={1,-2,3,-4} → out_valid at issue+5, out_data rows={1,-2,3,-4} sign-extended, done one cycle after the handshake.
- cfg rows=1, cols=2 (2×3 tiles), core_y=0x7F every row, all ready → two results: row 0 then row 1, each 381 per row, six consecutive issue cycles, no bubbles.
- Same job with op_valid toggling 1/0 → identical results and order. core_cen stays high during gaps while tags are valid.
- out_ready=0 held 10 cycles with a result pending → core_cen=0, tags frozen, no op issue. On release, results are correct and in order.
- ACC_WIDTH=8, four column tiles of 0x7F → out_data row = 0xFC (modulo wrap).
- rstn pulsed low mid-RUN → all outputs at reset values immediately. A new start afterwards completes with correct data.
